muls_x3y3_seq: RTL and testbench
================================

# muls_x3y3_seq

Sequential signed 3×3-bit multiplier behind an 8-bit packed I/O pin interface (clock, reset and both operands on `io_in`; product, sign and ready on `io_out`). It captures two's-complement operands, computes the product over several clock cycles using an add/subtract accumulator, then presents the result with a one-cycle ready pulse. It is the signed multiplier tile of the arithmetic demo set, alongside the half-adder and full-adder tiles.

## Interface
- `X_WIDTH`, default 3: multiplicand width, two's complement. Only 3 is supported.
- `Y_WIDTH`, default 3: multiplier width, two's complement. Only 3 is supported.
- `P_WIDTH`, default 6: product width, two's complement. Only 6 is supported.
- `io_in[0]` (clk), input, 1: the single clock; all state updates on its rising edge.
- `io_in[1]` (rst), input, 1: reset, asynchronous and active-high.
- `io_in[4:2]` (x), input, 3: multiplicand, signed.
- `io_in[7:5]` (y), input, 3: multiplier, signed.
- `io_out[5:0]` (p), output, 6: product register, two's complement.
- `io_out[6]` (s), output, 1: product sign; always equals `p[5]`.
- `io_out[7]` (rdy), output, 1: result-valid pulse.

## Operation
- FSM states: LOAD → B0 → B1 → B2 → DONE → LOAD. The FSM free-runs with no start input and no idle state.
- LOAD: capture `x` and `y` into internal operand registers, and clear the 6-bit accumulator `acc`. Call the sign-extended `x` `sx` (6 bits).
- B0: if `y[0]`, `acc += sx`.
- B1: if `y[1]`, `acc += sx<<1`.
- B2: if `y[2]`, `acc -= sx<<2`. The MSB of `y` carries negative weight. On this edge, load the final accumulator value into `p`, drive `s = p[5]`, and set `rdy = 1`.
- DONE: on the edge leaving DONE, clear `rdy`; `p` and `s` keep their value.
- All arithmetic is 6-bit modulo 2^6. The full result range is −12..+16, so it never overflows. In particular, −4×−4 = +16 = `010000`.
- Operands are sampled only at the LOAD edge. Input changes in any other state have no effect on the computation in progress.
- `p` and `s` change only at the B2 edge. Between results they hold the last product.
- The adder/subtractor is combinational within one cycle and may be built from full-adder and half-adder cells. Subtraction is implemented as add of the inverted operand with carry-in 1.
- Reset (asynchronous, any time including mid-computation):
  - state = LOAD, `acc` = 0, operand registers = 0;
  - `p` = 0, `s` = 0, `rdy` = 0.
  - A computation interrupted by reset produces no `rdy` pulse and leaves no partial result on `p`.

## Timing
- Throughput: one result every 5 clock cycles.
- After rst deasserts:
  - rising edge 1 (LOAD) captures operands;
  - edges 2, 3, 4 execute B0, B1, B2;
  - `p`, `s` and `rdy = 1` are valid immediately after edge 4;
  - `rdy` falls after edge 5;
  - edge 6 is the next LOAD.
- Latency from capture edge to result: 3 edges.
- `rdy` is high for exactly one clock period per result, and only while the state is DONE.
- All outputs are registered; there is no combinational path from `x`/`y` to `io_out`.
- Reset asserted during DONE clears `rdy` immediately, asynchronously.

## Test plan
- Reset, then x=3, y=3 held: after edge 4, p=`001001` (9), s=0, rdy=1; after edge 5, rdy=0 and p stays 9.
- x=−4 (`100`), y=−4 (`100`): p=`010000` (+16), s=0.
- x=−4, y=3: p=`110100` (−12), s=1. Also x=3, y=−1: p=`111101` (−3), s=1.
- x=0 with every y value, and every x value with y=0: p=0, s=0. Sweep all 64 (x, y) pairs against a signed reference model; rdy must pulse every 5 cycles.
- Change x/y during B0–B2: the result reflects only the values captured at LOAD. New values are used only in the next 5-cycle period.
- Assert rst during B1: p=0, s=0, rdy=0 immediately. After release, the first result appears exactly 4 edges later with no spurious rdy.

Source files
------------

// File: rtl/muls_x3y3_seq.sv
// -----------------------------------------------------------------------------
// muls_x3y3_seq
//
// Sequential signed 3x3-bit multiplier behind an 8-bit packed pin interface.
// A free-running five-state FSM (LOAD, B0, B1, B2, DONE) captures the
// operands, accumulates the partial products one multiplier bit per cycle
// and publishes the product together with a one-cycle ready pulse.
//
// Ports:
//   io_in[0]    clk  : single clock, rising-edge active
//   io_in[1]    rst  : asynchronous, active-high reset
//   io_in[4:2]  x    : multiplicand, two's complement
//   io_in[7:5]  y    : multiplier, two's complement
//   io_out[5:0] p    : product register, two's complement
//   io_out[6]   s    : product sign (always equals p[5])
//   io_out[7]   rdy  : result-valid pulse, high only while in DONE
// -----------------------------------------------------------------------------
module muls_x3y3_seq #(
   parameter int X_WIDTH = 3,
   parameter int Y_WIDTH = 3,
   parameter int P_WIDTH = 6
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic [2:0] {
      ST_LOAD = 3'd0,
      ST_B0   = 3'd1,
      ST_B1   = 3'd2,
      ST_B2   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Ripple-carry adder built from full-adder cells. The carry out of the
   // top bit is discarded: all arithmetic is modulo 2^6.
   function automatic logic [5:0] add6(input logic [5:0] a,
                                       input logic [5:0] b,
                                       input logic       cin);
      logic [5:0] sum;
      logic       carry;
      sum   = 6'd0;
      carry = cin;
      for (int i = 0; i < 5; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      sum[5] = a[5] ^ b[5] ^ carry;
      return sum;
   endfunction

   logic                 clk_s;
   logic                 rst_s;
   logic [X_WIDTH-1:0]   x_in_s;
   logic [Y_WIDTH-1:0]   y_in_s;

   state_t               state_q, state_d;
   logic [X_WIDTH-1:0]   x_q, x_d;
   logic [Y_WIDTH-1:0]   y_q, y_d;
   logic [P_WIDTH-1:0]   acc_q, acc_d;
   logic [P_WIDTH-1:0]   p_q, p_d;
   logic                 s_q, s_d;
   logic                 rdy_q, rdy_d;

   logic [P_WIDTH-1:0]   sx_s;
   logic [P_WIDTH-1:0]   sx_sh1_s;
   logic [P_WIDTH-1:0]   sx_sh2_s;
   logic [P_WIDTH-1:0]   fin_s;

   assign clk_s  = io_in[0];
   assign rst_s  = io_in[1];
   assign x_in_s = io_in[4:2];
   assign y_in_s = io_in[7:5];

   // Sign-extended multiplicand and its weighted copies for bits 1 and 2.
   assign sx_s     = {{3{x_q[2]}}, x_q};
   assign sx_sh1_s = {sx_s[4:0], 1'b0};
   assign sx_sh2_s = {sx_s[3:0], 2'b00};

   // Next-state and datapath logic for the free-running multiply sequence.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      p_d     = p_q;
      s_d     = s_q;
      rdy_d   = rdy_q;
      fin_s   = acc_q;
      case (state_q)
         ST_LOAD: begin
            x_d     = x_in_s;
            y_d     = y_in_s;
            acc_d   = 6'd0;
            rdy_d   = 1'b0;
            state_d = ST_B0;
         end
         ST_B0: begin
            if (y_q[0]) begin
               acc_d = add6(acc_q, sx_s, 1'b0);
            end else begin
               acc_d = acc_q;
            end
            state_d = ST_B1;
         end
         ST_B1: begin
            if (y_q[1]) begin
               acc_d = add6(acc_q, sx_sh1_s, 1'b0);
            end else begin
               acc_d = acc_q;
            end
            state_d = ST_B2;
         end
         ST_B2: begin
            // The multiplier MSB has weight -4: subtract via inverted
            // operand with carry-in 1.
            if (y_q[2]) begin
               fin_s = add6(acc_q, ~sx_sh2_s, 1'b1);
            end else begin
               fin_s = acc_q;
            end
            acc_d   = fin_s;
            p_d     = fin_s;
            s_d     = fin_s[5];
            rdy_d   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            rdy_d   = 1'b0;
            state_d = ST_LOAD;
         end
         default: begin
            acc_d   = 6'd0;
            rdy_d   = 1'b0;
            state_d = ST_LOAD;
         end
      endcase
   end

   // State, operand, accumulator and output registers.
   always_ff @(posedge clk_s or posedge rst_s) begin
      if (rst_s) begin
         state_q <= ST_LOAD;
         x_q     <= 3'd0;
         y_q     <= 3'd0;
         acc_q   <= 6'd0;
         p_q     <= 6'd0;
         s_q     <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         s_q     <= s_d;
         rdy_q   <= rdy_d;
      end
   end

   assign io_out = {rdy_q, s_q, p_q};

endmodule

// File: tb/tb_muls_x3y3_seq.sv
// -----------------------------------------------------------------------------
// tb_muls_x3y3_seq
//
// Self-checking bench for muls_x3y3_seq. A cycle-level reference model
// (operands sampled every fifth edge after reset, signed product published
// three edges later, ready for one period) is compared against io_out on
// every falling edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_muls_x3y3_seq;

   logic       clk;
   logic       rst;
   logic [2:0] x;
   logic [2:0] y;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int total;
   int bad;

   // Reference model state
   int         ph;        // edges since reset, modulo 5
   int         prod_m;    // product of operands captured at the sampling edge
   logic [5:0] exp_p;
   logic       exp_rdy;
   logic       cmp_en;
   int         gap;
   logic       gap_valid;

   assign io_in = {y, x, rst, clk};

   muls_x3y3_seq dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one result per five edges, operands sampled on edge 0.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph      <= 0;
         prod_m  <= 0;
         exp_p   <= 6'd0;
         exp_rdy <= 1'b0;
      end else begin
         if (ph == 0) prod_m <= int'($signed(x)) * int'($signed(y));
         if (ph == 3) begin
            exp_p   <= prod_m[5:0];
            exp_rdy <= 1'b1;
         end
         if (ph == 4) exp_rdy <= 1'b0;
         ph <= (ph + 1) % 5;
      end
   end

   // Per-cycle comparison of the DUT against the model, plus ready spacing.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("p_cycle",   {26'd0, io_out[5:0]}, {26'd0, exp_p});
         chk("s_cycle",   {31'd0, io_out[6]},   {31'd0, exp_p[5]});
         chk("rdy_cycle", {31'd0, io_out[7]},   {31'd0, exp_rdy});
         if (rst) begin
            gap_valid = 1'b0;
            gap       = 0;
         end else begin
            gap++;
            if (io_out[7]) begin
               if (gap_valid) chk("rdy_period", gap, 5);
               gap_valid = 1'b1;
               gap       = 0;
            end
         end
      end
   end

   // Run one multiply aligned to the sampling edge; operands are scrambled
   // right after capture to show they are not used mid-computation.
   task automatic run_pair(input logic [2:0] xa, input logic [2:0] ya,
                           input logic use_lit, input logic [5:0] lit);
      int n;
      int pe;
      logic [5:0] pexp;
      logic [5:0] p_hold;
      n = 0;
      @(negedge clk);
      while (ph != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("align", {31'd0, (ph == 0)}, 32'd1);
      x = xa;
      y = ya;
      pe   = int'($signed(xa)) * int'($signed(ya));
      pexp = pe[5:0];
      @(posedge clk);
      @(negedge clk);
      x = 3'($urandom_range(0, 7));
      y = 3'($urandom_range(0, 7));
      repeat (3) @(posedge clk);
      #1;
      chk("pair_p",   {26'd0, io_out[5:0]}, {26'd0, pexp});
      chk("pair_s",   {31'd0, io_out[6]},   {31'd0, pexp[5]});
      chk("pair_rdy", {31'd0, io_out[7]},   32'd1);
      if (use_lit) chk("lit_p", {26'd0, io_out[5:0]}, {26'd0, lit});
      p_hold = io_out[5:0];
      @(posedge clk);
      #1;
      chk("rdy_fall", {31'd0, io_out[7]},   32'd0);
      chk("p_hold",   {26'd0, io_out[5:0]}, {26'd0, p_hold});
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cmp_en    = 1'b0;
      gap       = 0;
      gap_valid = 1'b0;
      rst       = 1'b1;
      x         = 3'd0;
      y         = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("reset_out", {24'd0, io_out}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;

      // Hand-computed anchors
      run_pair(3'd3, 3'd3, 1'b1, 6'b001001);
      run_pair(3'b100, 3'b100, 1'b1, 6'b010000);
      run_pair(3'b100, 3'd3, 1'b1, 6'b110100);
      run_pair(3'd3, 3'b111, 1'b1, 6'b111101);
      run_pair(3'd0, 3'b101, 1'b1, 6'b000000);
      run_pair(3'b110, 3'd0, 1'b1, 6'b000000);

      // Full operand sweep
      for (int i = 0; i < 64; i++) begin
         run_pair(3'(i), 3'(i >> 3), 1'b0, 6'd0);
      end

      // Random pairs
      for (int i = 0; i < 30; i++) begin
         run_pair(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 6'd0);
      end

      // Reset in the middle of a computation (state B1)
      run_pair(3'd2, 3'd3, 1'b1, 6'd6);
      x = 3'd3;
      y = 3'd2;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (ph != 2 && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("align_b1", {31'd0, (ph == 2)}, 32'd1);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out", {24'd0, io_out}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      // First edge after release is a sampling edge; result four edges on.
      x = 3'b101;
      y = 3'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("no_spurious_rdy", {31'd0, io_out[7]}, 32'd0);
      @(posedge clk);
      #1;
      chk("post_rst_p",   {26'd0, io_out[5:0]}, {26'd0, 6'b111010});
      chk("post_rst_rdy", {31'd0, io_out[7]},   32'd1);

      // Reset during DONE clears rdy at once
      #2;
      rst = 1'b1;
      #1;
      chk("done_rst_out", {24'd0, io_out}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      run_pair(3'b111, 3'b111, 1'b1, 6'd1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end

endmodule
